// File: rtl/stream_width_split.sv
// Wide-to-narrow stream splitter: holds one IN_W beat and emits it as RATIO words of
// OUT_W bits over a valid/rdy handshake. A new beat may be accepted on the cycle the
// previous beat's last word is consumed, so there is no bubble between beats.
// Optional: define STREAM_WIDTH_SPLIT_COUNT_EN to add a 32-bit word_count output
// that counts completed output transfers.
// IN_W must be an integer multiple of OUT_W with IN_W/OUT_W >= 2.
module stream_width_split #(
   parameter int unsigned IN_W      = 128,
   parameter int unsigned OUT_W     = 32,
   parameter int unsigned MSW_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             si_valid,
   output logic             si_rdy,
   input  logic [IN_W-1:0]  si_data,
   output logic             so_valid,
   input  logic             so_rdy,
   output logic [OUT_W-1:0] so_data,
   output logic             so_last
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
   ,
   output logic [31:0]      word_count
`endif
);

   localparam int unsigned RATIO = IN_W / OUT_W;
   localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(RATIO - 1);

   logic [IN_W-1:0]  hold_q, hold_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             full_q, full_d;
   logic             in_xfer;
   logic             out_xfer;

   assign so_valid = full_q;
   assign so_last  = full_q & (idx_q == LastIdx);
   // si_rdy depends on so_rdy only, never on si_valid.
   assign si_rdy   = ~full_q | (so_rdy & so_last);
   assign in_xfer  = si_valid & si_rdy;
   assign out_xfer = full_q & so_rdy;

   // Output word mux: pick the held word addressed by idx in the configured order.
   always_comb begin
      so_data = '0;
      for (int k = 0; k < int'(RATIO); k++) begin
         if (idx_q == IDX_W'(k)) begin
            if (MSW_FIRST != 0) begin
               so_data = hold_q[(int'(RATIO) - 1 - k) * int'(OUT_W) +: OUT_W];
            end else begin
               so_data = hold_q[k * int'(OUT_W) +: OUT_W];
            end
         end
      end
   end

   // Next-state: advance idx per word, drop full after the last word, and load a new
   // beat (restarting at word 0) whenever an input transfer happens.
   always_comb begin
      hold_d = hold_q;
      idx_d  = idx_q;
      full_d = full_q;
      if (out_xfer) begin
         if (idx_q != LastIdx) begin
            idx_d = idx_q + 1'b1;
         end else begin
            full_d = 1'b0;
            idx_d  = '0;
         end
      end
      if (in_xfer) begin
         hold_d = si_data;
         idx_d  = '0;
         full_d = 1'b1;
      end
   end

   // State registers; reset discards any held beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         idx_q  <= '0;
         full_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         idx_q  <= idx_d;
         full_q <= full_d;
      end
   end

`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
   logic [31:0] count_q, count_d;

   assign count_d    = out_xfer ? count_q + 32'd1 : count_q;
   assign word_count = count_q;

   // Completed output transfer counter, wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
`endif

endmodule

// File: tb/tb_stream_width_split.sv
// Directed self-checking bench for stream_width_split. Two instances share stimulus:
// u_lsw (MSW_FIRST=0) and u_msw (MSW_FIRST=1). Inputs change and outputs are sampled
// 1-2 time units after the rising edge.
module tb_stream_width_split;

   logic          clk;
   logic          rst_n;
   logic          si_valid;
   logic [127:0]  si_data;
   logic          so_rdy;

   logic          si_rdy_l, so_valid_l, so_last_l;
   logic [31:0]   so_data_l;
   logic          si_rdy_m, so_valid_m, so_last_m;
   logic [31:0]   so_data_m;
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
   logic [31:0]   word_count_l, word_count_m;
`endif

   int checks = 0;
   int errors = 0;

   stream_width_split #(.IN_W(128), .OUT_W(32), .MSW_FIRST(0)) u_lsw (
      .clk      (clk),
      .rst_n    (rst_n),
      .si_valid (si_valid),
      .si_rdy   (si_rdy_l),
      .si_data  (si_data),
      .so_valid (so_valid_l),
      .so_rdy   (so_rdy),
      .so_data  (so_data_l),
      .so_last  (so_last_l)
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
      ,
      .word_count (word_count_l)
`endif
   );

   stream_width_split #(.IN_W(128), .OUT_W(32), .MSW_FIRST(1)) u_msw (
      .clk      (clk),
      .rst_n    (rst_n),
      .si_valid (si_valid),
      .si_rdy   (si_rdy_m),
      .si_data  (si_data),
      .so_valid (so_valid_m),
      .so_rdy   (so_rdy),
      .so_data  (so_data_m),
      .so_last  (so_last_m)
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
      ,
      .word_count (word_count_m)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller has presented a beat with so_rdy=1 in the current cycle; drain all 4 words.
   task automatic drain(input string tag, input logic [127:0] beat);
      for (int k = 0; k < 4; k++) begin
         tick();
         si_valid = 1'b0;
         #1;
         check({tag, "_valid"}, so_valid_l, 1'b1);
         check({tag, "_data_lsw"}, so_data_l, beat[k*32 +: 32]);
         check({tag, "_data_msw"}, so_data_m, beat[(3-k)*32 +: 32]);
         check({tag, "_last"}, so_last_l, (k == 3));
         check({tag, "_si_rdy"}, si_rdy_l, (k == 3));
      end
      tick();
      #1;
      check({tag, "_empty"}, so_valid_l, 1'b0);
   endtask

   logic [127:0] beat1, beat_a, beat_b, beat_c, beat_d, beat_e;
   logic         pat [12];
   int           k;

   initial begin
      beat1  = 128'h44444444_33333333_22222222_11111111;
      beat_a = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
      beat_b = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
      beat_c = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
      beat_d = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
      beat_e = 128'h000000DD_000000CC_000000BB_000000AA;
      pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset state
      rst_n    = 1'b0;
      si_valid = 1'b0;
      si_data  = '0;
      so_rdy   = 1'b0;
      #3;
      check("rst_valid", so_valid_l, 1'b0);
      check("rst_si_rdy", si_rdy_l, 1'b1);
      check("rst_last", so_last_l, 1'b0);
      check("rst_data", so_data_l, 32'h0);
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
      check("rst_count", word_count_l, 32'd0);
`endif
      tick();
      rst_n = 1'b1;

      // Single beat, both word orders
      si_valid = 1'b1;
      si_data  = beat1;
      so_rdy   = 1'b1;
      #1;
      check("b1_si_rdy", si_rdy_l, 1'b1);
      check("b1_pre_valid", so_valid_l, 1'b0);
      drain("b1", beat1);

      // Back-to-back beats A then B: 8 words, no gap
      si_valid = 1'b1;
      si_data  = beat_a;
      so_rdy   = 1'b1;
      #1;
      check("ab_si_rdy0", si_rdy_l, 1'b1);
      for (int j = 0; j < 8; j++) begin
         tick();
         if (j == 0) si_data = beat_b;
         if (j == 4) si_valid = 1'b0;
         #1;
         check("ab_valid", so_valid_l, 1'b1);
         check("ab_data", so_data_l, (j < 4) ? beat_a[j*32 +: 32] : beat_b[(j-4)*32 +: 32]);
         check("ab_last", so_last_l, ((j % 4) == 3));
         check("ab_si_rdy", si_rdy_l, ((j % 4) == 3));
      end
      tick();
      #1;
      check("ab_empty", so_valid_l, 1'b0);
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
      check("ab_count12", word_count_l, 32'd12);
`endif

      // Back-pressure mid-beat: outputs hold while so_rdy=0
      si_valid = 1'b1;
      si_data  = beat_c;
      so_rdy   = 1'b1;
      tick();
      k = 0;
      for (int c = 0; c < 12 && k < 4; c++) begin
         si_valid = 1'b1;  // must be ignored while full and not finishing
         si_data  = beat_d;
         so_rdy   = pat[c];
         #1;
         check("st_valid", so_valid_l, 1'b1);
         check("st_data", so_data_l, beat_c[k*32 +: 32]);
         check("st_last", so_last_l, (k == 3));
         check("st_si_rdy", si_rdy_l, (pat[c] && k == 3));
         if (pat[c]) k++;
         if (k == 4) si_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      si_valid = 1'b0;
      so_rdy   = 1'b1;
      #1;
      check("st_words_done", k, 4);
      check("st_empty", so_valid_l, 1'b0);

      // Asynchronous reset after 2 of 4 words sent
      tick();
      si_valid = 1'b1;
      si_data  = beat_d;
      so_rdy   = 1'b1;
      tick();
      si_valid = 1'b0;
      tick();
      tick();
      #1;
      check("ar_pre_data", so_data_l, beat_d[2*32 +: 32]);
      so_rdy = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_valid", so_valid_l, 1'b0);
      check("ar_si_rdy", si_rdy_l, 1'b1);
      check("ar_last", so_last_l, 1'b0);
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
      check("ar_count", word_count_l, 32'd0);
`endif
      tick();
      rst_n    = 1'b1;
      si_valid = 1'b1;
      si_data  = beat_e;
      so_rdy   = 1'b1;
      drain("ae", beat_e);
`ifdef STREAM_WIDTH_SPLIT_COUNT_EN
      check("ae_count4", word_count_l, 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog keeps the run bounded whatever the DUT does.
   initial begin
      #20000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
